// File: rtl/vga_monitor_pkg.sv
// Shared XGA timing constants, the frame-total helper and the monitor FSM states.
package vga_monitor_pkg;
    localparam int XGA_H_ACTIVE        = 1024;
    localparam int XGA_H_FRONT         = 24;
    localparam int XGA_H_SYNC          = 136;
    localparam int XGA_H_BACK          = 160;
    localparam int XGA_V_ACTIVE        = 768;
    localparam int XGA_V_FRONT         = 3;
    localparam int XGA_V_SYNC          = 6;
    localparam int XGA_V_BACK          = 29;
    localparam int XGA_SYNC_ACTIVE_LOW = 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } monitor_state_t;

    function automatic int calc_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction
endpackage

// File: rtl/vga_edge_detect.sv
// Registers one sync input as active-high and flags its assert/deassert edges.
module vga_edge_detect
    import vga_monitor_pkg::*;
#(
    parameter int SYNC_ACTIVE_LOW = XGA_SYNC_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic assert_pulse,
    output logic deassert_pulse
);
    localparam logic POL = (SYNC_ACTIVE_LOW != 0);

    logic level_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            level_reg <= sync_in ^ POL;
            prev_reg  <= level_reg;
        end
    end

    assign assert_pulse   = level_reg & ~prev_reg;
    assign deassert_pulse = ~level_reg & prev_reg;
endmodule

// File: rtl/vga_monitor.sv
// Receive-side VGA monitor: recovers beam position, verifies sync timing, signs frames.
// Define VGA_MONITOR_SIGNATURE_EN to build the frame signature accumulator.
module vga_monitor
    import vga_monitor_pkg::*;
#(
    parameter int H_ACTIVE        = XGA_H_ACTIVE,
    parameter int H_FRONT         = XGA_H_FRONT,
    parameter int H_SYNC          = XGA_H_SYNC,
    parameter int H_BACK          = XGA_H_BACK,
    parameter int V_ACTIVE        = XGA_V_ACTIVE,
    parameter int V_FRONT         = XGA_V_FRONT,
    parameter int V_SYNC          = XGA_V_SYNC,
    parameter int V_BACK          = XGA_V_BACK,
    parameter int SYNC_ACTIVE_LOW = XGA_SYNC_ACTIVE_LOW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic [15:0] frame_sum,
    output logic        frame_done
);
    localparam logic [11:0] H_TOTAL_C = 12'(calc_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
    localparam logic [11:0] H_LAST    = H_TOTAL_C - 12'd1;
    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [11:0] H_START   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_END     = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_TOTAL_C = 11'(calc_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
    localparam logic [10:0] V_LAST    = V_TOTAL_C - 11'd1;
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [10:0] V_START   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END     = 11'(V_SYNC + V_BACK + V_ACTIVE);

    // Bit 0 carries HS, bit 1 carries VS.
    logic [1:0] sync_raw;
    logic [1:0] sync_rise;
    logic [1:0] sync_fall;

    assign sync_raw = {vga_vs, vga_hs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            vga_edge_detect #(
                .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
            ) u_edge (
                .clk           (clk),
                .rst           (rst),
                .sync_in       (sync_raw[gi]),
                .assert_pulse  (sync_rise[gi]),
                .deassert_pulse(sync_fall[gi])
            );
        end
    endgenerate

    logic hs_rise, hs_fall, vs_rise, vs_fall;
    assign hs_rise = sync_rise[0];
    assign hs_fall = sync_fall[0];
    assign vs_rise = sync_rise[1];
    assign vs_fall = sync_fall[1];

    logic [11:0]    rgb_s1_reg;
    logic [11:0]    rgb_s2_reg;
    logic [11:0]    h_cnt_reg, h_cnt_next;
    logic [10:0]    v_cnt_reg, v_cnt_next;
    monitor_state_t state_reg, state_next;
    logic           violation;
    logic           err_event;
    logic           done_event;
    logic           line_err_s2_reg;
    logic           vs_rise_s2_reg;
    logic           frame_done_s2_reg;

    always_comb begin
        h_cnt_next = h_cnt_reg;
        if (hs_rise) begin
            h_cnt_next = '0;
        end else if (h_cnt_reg != 12'hFFF) begin
            h_cnt_next = h_cnt_reg + 12'd1;
        end
        v_cnt_next = v_cnt_reg;
        if (vs_rise) begin
            v_cnt_next = '0;
        end else if (hs_rise && (v_cnt_reg != 11'h7FF)) begin
            v_cnt_next = v_cnt_reg + 11'd1;
        end
    end

    // Assert edges test the position of the last pixel before the edge; deassert
    // edges test the position of the pixel that first shows the sync released.
    assign violation = (hs_rise && (h_cnt_reg != H_LAST))
                    || (!hs_rise && (h_cnt_reg == H_LAST))
                    || (hs_fall && (h_cnt_next != H_SYNC_C))
                    || (vs_fall && (v_cnt_next != V_SYNC_C))
                    || (vs_rise && (v_cnt_reg != V_LAST));

    assign err_event  = violation && (state_reg != SEARCH);
    assign done_event = vs_rise && (state_reg == LOCKED) && !violation;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SEARCH:  if (vs_rise) state_next = ACQUIRE;
            ACQUIRE: begin
                if (err_event) begin
                    state_next = SEARCH;
                end else if (vs_rise) begin
                    state_next = LOCKED;
                end
            end
            LOCKED:  if (err_event) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1_reg        <= '0;
            rgb_s2_reg        <= '0;
            h_cnt_reg         <= '0;
            v_cnt_reg         <= '0;
            state_reg         <= SEARCH;
            line_err_s2_reg   <= 1'b0;
            vs_rise_s2_reg    <= 1'b0;
            frame_done_s2_reg <= 1'b0;
        end else begin
            rgb_s1_reg        <= {vga_r, vga_g, vga_b};
            rgb_s2_reg        <= rgb_s1_reg;
            h_cnt_reg         <= h_cnt_next;
            v_cnt_reg         <= v_cnt_next;
            state_reg         <= state_next;
            line_err_s2_reg   <= err_event;
            vs_rise_s2_reg    <= vs_rise;
            frame_done_s2_reg <= done_event;
        end
    end

    logic pixel_ok;
    assign pixel_ok = (h_cnt_reg >= H_START) && (h_cnt_reg < H_END)
                   && (v_cnt_reg >= V_START) && (v_cnt_reg < V_END)
                   && (state_reg != SEARCH);

    logic        pix_valid_reg;
    logic [10:0] pix_x_reg;
    logic [9:0]  pix_y_reg;
    logic [11:0] pix_rgb_reg;
    logic        frame_start_reg;
    logic        locked_reg;
    logic        line_err_reg;
    logic        frame_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_reg   <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            pix_rgb_reg     <= '0;
            frame_start_reg <= 1'b0;
            locked_reg      <= 1'b0;
            line_err_reg    <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            pix_valid_reg   <= pixel_ok;
            pix_x_reg       <= pixel_ok ? 11'(h_cnt_reg - H_START) : '0;
            pix_y_reg       <= pixel_ok ? 10'(v_cnt_reg - V_START) : '0;
            pix_rgb_reg     <= pixel_ok ? rgb_s2_reg : '0;
            frame_start_reg <= vs_rise_s2_reg;
            locked_reg      <= (state_reg == LOCKED);
            line_err_reg    <= line_err_s2_reg;
            frame_done_reg  <= frame_done_s2_reg;
        end
    end

`ifdef VGA_MONITOR_SIGNATURE_EN
    logic [15:0] acc_reg;
    logic [15:0] frame_sum_reg;

    // The snapshot takes the accumulator before the same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            frame_sum_reg <= '0;
        end else begin
            if (vs_rise_s2_reg) begin
                acc_reg <= '0;
            end else if (pixel_ok) begin
                acc_reg <= {acc_reg[14:0], acc_reg[15]} ^ {4'h0, rgb_s2_reg};
            end
            if (frame_done_s2_reg) begin
                frame_sum_reg <= acc_reg;
            end
        end
    end

    assign frame_sum = frame_sum_reg;
`else
    assign frame_sum = '0;
`endif

    assign pix_valid   = pix_valid_reg;
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign pix_rgb     = pix_rgb_reg;
    assign frame_start = frame_start_reg;
    assign locked      = locked_reg;
    assign line_err    = line_err_reg;
    assign frame_done  = frame_done_reg;
endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor on a reduced 8x6 raster (H 4/1/2/1, V 3/1/1/1, active-low syncs).
module tb_vga_monitor;
    import vga_monitor_pkg::*;

    localparam int LOG_N = 1024;
`ifdef VGA_MONITOR_SIGNATURE_EN
    localparam int SUM_ONES = 'h0FFF;
`else
    localparam int SUM_ONES = 0;
`endif

    logic        clk;
    logic        rst;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        line_err;
    logic [15:0] frame_sum;
    logic        frame_done;

    vga_monitor #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .frame_start(frame_start),
        .locked     (locked),
        .line_err   (line_err),
        .frame_sum  (frame_sum),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;

    int log_valid  [LOG_N];
    int log_x      [LOG_N];
    int log_y      [LOG_N];
    int log_rgb    [LOG_N];
    int log_fs     [LOG_N];
    int log_locked [LOG_N];
    int log_err    [LOG_N];
    int log_sum    [LOG_N];
    int log_done   [LOG_N];

    always @(posedge clk) cyc <= cyc + 1;

    // log[c] holds the outputs right after posedge c; a pixel sampled at c shows at c+2.
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            log_valid[cyc]  <= int'(pix_valid);
            log_x[cyc]      <= int'(pix_x);
            log_y[cyc]      <= int'(pix_y);
            log_rgb[cyc]    <= int'(pix_rgb);
            log_fs[cyc]     <= int'(frame_start);
            log_locked[cyc] <= int'(locked);
            log_err[cyc]    <= int'(line_err);
            log_sum[cyc]    <= int'(frame_sum);
            log_done[cyc]   <= int'(frame_done);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input logic hs_a, input logic vs_a, input logic [11:0] rgb,
                        output int smp);
        @(negedge clk);
        vga_hs = hs_a;
        vga_vs = vs_a;
        {vga_r, vga_g, vga_b} = rgb;
        smp = cyc + 1;
    endtask

    task automatic idle(input int n);
        int s;
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 12'h000, s);
    endtask

    // Lines 0..5: VS low on line 0; each line HS low for h 0..1, active h 3..6 on lines 2..4.
    task automatic send_frame(input logic [11:0] first_rgb, input logic [11:0] rest_rgb,
                              input int short_line, input int n_lines,
                              output int vs_smp, output int fa_smp, output int err_smp);
        int s;
        int len;
        logic act;
        logic [11:0] px;
        vs_smp = 0;
        fa_smp = 0;
        err_smp = 0;
        for (int ln = 0; ln < n_lines; ln++) begin
            len = (ln == short_line) ? 7 : 8;
            for (int h = 0; h < len; h++) begin
                act = (ln >= 2) && (ln < 5) && (h >= 3) && (h < 7);
                px = !act ? 12'h000 : ((ln == 2 && h == 3) ? first_rgb : rest_rgb);
                tick(h >= 2, ln >= 1, px, s);
                if (ln == 0 && h == 0) vs_smp = s;
                if (ln == 2 && h == 3) fa_smp = s;
                if (ln == short_line + 1 && h == 0) err_smp = s;
            end
        end
    endtask

    initial begin
        int vs_a, vs_b, vs_c, vs_d, vs_e, vs_f, vs_g, vs_h, vs_i, vs_j;
        int fa_b, err_d, rst_smp, n, dmy, dmy2;

        rst = 1'b1;
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        {vga_r, vga_g, vga_b} = 12'h000;
        idle(3);

        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_pix_rgb", int'(pix_rgb), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_line_err", int'(line_err), 0);
        chk("rst_frame_sum", int'(frame_sum), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_state", int'(dut.state_reg), int'(SEARCH));

        rst = 1'b0;
        idle(2);
        send_frame(12'h000, 12'h000, -1, 6, vs_a, dmy, dmy2);
        send_frame(12'hABC, 12'h000, -1, 6, vs_b, fa_b, dmy2);
        send_frame(12'h001, 12'h001, -1, 6, vs_c, dmy, dmy2);
        send_frame(12'h001, 12'h001, 3, 6, vs_d, dmy, err_d);
        send_frame(12'h000, 12'h000, -1, 6, vs_e, dmy, dmy2);
        send_frame(12'h000, 12'h000, -1, 6, vs_f, dmy, dmy2);

        chk("frame_start_a", log_fs[vs_a + 2], 1);
        chk("frame_start_a_width", log_fs[vs_a + 3], 0);
        chk("frame_start_b", log_fs[vs_b + 2], 1);
        chk("locked_b_early", log_locked[vs_b + 1], 0);
        chk("locked_b_rise", log_locked[vs_b + 2], 1);

        chk("porch_valid", log_valid[fa_b + 1], 0);
        chk("first_valid", log_valid[fa_b + 2], 1);
        chk("first_x", log_x[fa_b + 2], 0);
        chk("first_y", log_y[fa_b + 2], 0);
        chk("first_rgb", log_rgb[fa_b + 2], 'hABC);
        chk("second_x", log_x[fa_b + 3], 1);
        chk("second_rgb", log_rgb[fa_b + 3], 0);
        chk("last_x", log_x[fa_b + 21], 3);
        chk("last_y", log_y[fa_b + 21], 2);
        chk("front_porch_valid", log_valid[fa_b + 22], 0);

        chk("frame_done_c", log_done[vs_c + 2], 1);
        chk("frame_done_d", log_done[vs_d + 2], 1);
        chk("frame_sum_d", log_sum[vs_d + 2], SUM_ONES);

        chk("short_line_err", log_err[err_d + 2], 1);
        chk("short_locked_before", log_locked[err_d + 1], 1);
        chk("short_locked_drop", log_locked[err_d + 2], 0);
        chk("search_pix_valid", log_valid[err_d + 5], 0);
        n = 0;
        for (int i = vs_d; i < vs_e + 2; i++) n += log_err[i];
        chk("line_err_count", n, 1);
        chk("relock_e", log_locked[vs_e + 2], 0);
        chk("relock_f_early", log_locked[vs_f + 1], 0);
        chk("relock_f", log_locked[vs_f + 2], 1);

        send_frame(12'h000, 12'h000, -1, 3, vs_g, dmy, dmy2);
        rst_smp = cyc + 1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        send_frame(12'h000, 12'h000, -1, 6, vs_h, dmy, dmy2);
        send_frame(12'h001, 12'h001, -1, 6, vs_i, dmy, dmy2);
        send_frame(12'h000, 12'h000, -1, 6, vs_j, dmy, dmy2);
        idle(4);

        chk("midrst_frame_done_g", log_done[vs_g + 2], 1);
        chk("midrst_locked", log_locked[rst_smp], 0);
        n = 0;
        for (int i = rst_smp; i < vs_i + 2; i++) n += log_done[i];
        chk("midrst_no_frame_done", n, 0);
        chk("midrst_relock", log_locked[vs_i + 2], 1);
        chk("midrst_frame_done_j", log_done[vs_j + 2], 1);
        chk("midrst_frame_sum_j", log_sum[vs_j + 2], SUM_ONES);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
